// File: rtl/count_chk_pkg.sv
// Shared definitions for the count sequence checker.
package count_chk_pkg;

  localparam int unsigned DEF_WIDTH     = 4;
  localparam int unsigned DEF_ERR_CNT_W = 8;

  // Width of the consecutive-match run counter (LOCK_COUNT is 1..15).
  localparam int unsigned GOOD_RUN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear first, otherwise increment unless already all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_seq_checker.sv
// Monitors a counter bus, locks onto a valid increment sequence and reports
// mismatches, restarts and wrap-arounds.
module count_seq_checker
  import count_chk_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned ERR_CNT_W  = DEF_ERR_CNT_W,
  parameter int unsigned LOCK_COUNT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     q_in,
  input  logic                 sample_en,
  input  logic                 cnt_clr,
  output logic                 locked,
  output logic [WIDTH-1:0]     expected,
  output logic                 err_pulse,
  output logic                 restart_seen,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ERR_CNT_W-1:0] wrap_count
);

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        prev_q, prev_d;
  logic [WIDTH-1:0]        exp_q, exp_d;
  logic [GOOD_RUN_W-1:0]   good_run_q, good_run_d;
  logic                    err_q, err_d;
  logic                    restart_q, restart_d;
  logic                    err_inc;
  logic                    wrap_inc;

  logic [WIDTH-1:0]        q_plus1;
  logic [GOOD_RUN_W-1:0]   good_run_inc;
  logic                    match;

  assign q_plus1      = q_in + 1'b1;
  assign good_run_inc = good_run_q + 1'b1;
  assign match        = (q_in == exp_q);

  // Next-state and event decode; everything holds unless a sample is taken.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    exp_d      = exp_q;
    good_run_d = good_run_q;
    err_d      = 1'b0;
    restart_d  = 1'b0;
    err_inc    = 1'b0;
    wrap_inc   = 1'b0;

    if (sample_en) begin
      prev_d = q_in;
      exp_d  = q_plus1;
      unique case (state_q)
        ST_IDLE: begin
          good_run_d = '0;
          state_d    = ST_SYNC;
        end
        ST_SYNC: begin
          if (match) begin
            good_run_d = good_run_inc;
            if (good_run_inc == GOOD_RUN_W'(LOCK_COUNT)) begin
              state_d = ST_LOCKED;
            end
          end else begin
            good_run_d = '0;
          end
        end
        ST_LOCKED: begin
          if (match) begin
            // A matched 0 can only follow all-ones.
            wrap_inc = (q_in == '0) && (prev_q == {WIDTH{1'b1}});
          end else if (q_in == '0) begin
            // Counter restarted from zero: resynchronise silently.
            restart_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_inc    = 1'b1;
            good_run_d = '0;
            state_d    = ST_SYNC;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          good_run_d = '0;
        end
      endcase
    end
  end

  // FSM, prediction and pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      prev_q     <= '0;
      exp_q      <= '0;
      good_run_q <= '0;
      err_q      <= 1'b0;
      restart_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      exp_q      <= exp_d;
      good_run_q <= good_run_d;
      err_q      <= err_d;
      restart_q  <= restart_d;
    end
  end

  sat_counter #(
    .WIDTH (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .clr   (cnt_clr),
    .count (err_count)
  );

  sat_counter #(
    .WIDTH (ERR_CNT_W)
  ) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_inc),
    .clr   (cnt_clr),
    .count (wrap_count)
  );

  assign locked       = (state_q == ST_LOCKED);
  assign expected     = exp_q;
  assign err_pulse    = err_q;
  assign restart_seen = restart_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed self-checking bench for count_seq_checker.
module tb_count_seq_checker;

  logic       clk;
  logic       reset;
  logic [3:0] q_in;
  logic       sample_en;
  logic       cnt_clr;
  logic       locked;
  logic [3:0] expected;
  logic       err_pulse;
  logic       restart_seen;
  logic [7:0] err_count;
  logic [7:0] wrap_count;

  int n_checks = 0;
  int n_errors = 0;

  count_seq_checker #(
    .WIDTH      (4),
    .ERR_CNT_W  (8),
    .LOCK_COUNT (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .q_in         (q_in),
    .sample_en    (sample_en),
    .cnt_clr      (cnt_clr),
    .locked       (locked),
    .expected     (expected),
    .err_pulse    (err_pulse),
    .restart_seen (restart_seen),
    .err_count    (err_count),
    .wrap_count   (wrap_count)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Drive one enabled sample on the falling edge, return just after the rising edge.
  task automatic drive(input logic [3:0] q, input logic clr);
    @(negedge clk);
    q_in      = q;
    sample_en = 1'b1;
    cnt_clr   = clr;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  task automatic idle(input logic [3:0] q);
    @(negedge clk);
    q_in      = q;
    sample_en = 1'b0;
    cnt_clr   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    q_in      = '0;
    sample_en = 1'b0;
    cnt_clr   = 1'b0;
    reset     = 1'b1;
    #1 reset  = 1'b0;
    #11;
    check_eq("rst_locked", locked, 0);
    check_eq("rst_expected", expected, 0);
    check_eq("rst_err_pulse", err_pulse, 0);
    check_eq("rst_restart", restart_seen, 0);
    check_eq("rst_err_count", err_count, 0);
    check_eq("rst_wrap_count", wrap_count, 0);
    #3 reset = 1'b1;
    #1;

    // Acquire lock on 0,1,2,3 (3 consecutive increments after the first sample).
    drive(4'd0, 1'b0);
    check_eq("idle_expected", expected, 1);
    check_eq("idle_locked", locked, 0);
    drive(4'd1, 1'b0);
    drive(4'd2, 1'b0);
    check_eq("sync_locked", locked, 0);
    drive(4'd3, 1'b0);
    check_eq("lock_locked", locked, 1);
    check_eq("lock_err_pulse", err_pulse, 0);
    drive(4'd4, 1'b0);
    check_eq("lock_expected", expected, 5);

    // Run up through a wrap.
    for (int v = 5; v <= 15; v++) drive(4'(v), 1'b0);
    check_eq("pre_wrap_count", wrap_count, 0);
    drive(4'd0, 1'b0);
    check_eq("wrap_count", wrap_count, 1);
    check_eq("wrap_locked", locked, 1);
    drive(4'd1, 1'b0);
    check_eq("wrap_err_count", err_count, 0);
    check_eq("wrap_expected", expected, 2);

    // Restart while expecting 7.
    for (int v = 2; v <= 6; v++) drive(4'(v), 1'b0);
    check_eq("pre_restart_expected", expected, 7);
    drive(4'd0, 1'b0);
    check_eq("restart_pulse", restart_seen, 1);
    check_eq("restart_locked", locked, 1);
    check_eq("restart_expected", expected, 1);
    check_eq("restart_err_pulse", err_pulse, 0);
    check_eq("restart_wrap", wrap_count, 1);
    drive(4'd1, 1'b0);
    check_eq("restart_clear", restart_seen, 0);
    check_eq("restart_match_exp", expected, 2);
    check_eq("restart_match_err", err_pulse, 0);

    // Mismatch while expecting 9, then relock.
    for (int v = 2; v <= 8; v++) drive(4'(v), 1'b0);
    check_eq("pre_err_expected", expected, 9);
    drive(4'd5, 1'b0);
    check_eq("err_pulse", err_pulse, 1);
    check_eq("err_count1", err_count, 1);
    check_eq("err_locked", locked, 0);
    check_eq("err_expected", expected, 6);
    drive(4'd6, 1'b0);
    check_eq("err_pulse_clear", err_pulse, 0);
    drive(4'd7, 1'b0);
    check_eq("relock_early", locked, 0);
    drive(4'd8, 1'b0);
    check_eq("relock", locked, 1);

    // 300 more mismatch/relock rounds: 301 errors saturate at 255.
    for (int i = 0; i < 300; i++) begin
      drive(4'd5, 1'b0);
      drive(4'd6, 1'b0);
      drive(4'd7, 1'b0);
      drive(4'd8, 1'b0);
      if (i == 252) check_eq("err_count_254", err_count, 254);
    end
    check_eq("err_count_sat", err_count, 255);
    check_eq("sat_locked", locked, 1);
    check_eq("sat_wrap", wrap_count, 1);

    // Clear coincident with an error: counters zero, pulse unaffected.
    drive(4'd5, 1'b1);
    check_eq("clr_err_count", err_count, 0);
    check_eq("clr_wrap_count", wrap_count, 0);
    check_eq("clr_err_pulse", err_pulse, 1);
    check_eq("clr_locked", locked, 0);
    drive(4'd6, 1'b0);
    drive(4'd7, 1'b0);
    drive(4'd8, 1'b0);

    // Build nonzero counts while locked, then reset asynchronously.
    for (int v = 9; v <= 15; v++) drive(4'(v), 1'b0);
    drive(4'd0, 1'b0);
    drive(4'd5, 1'b0);
    drive(4'd6, 1'b0);
    drive(4'd7, 1'b0);
    drive(4'd8, 1'b0);
    check_eq("pre_rst_err", err_count, 1);
    check_eq("pre_rst_wrap", wrap_count, 1);
    check_eq("pre_rst_locked", locked, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_locked", locked, 0);
    check_eq("arst_expected", expected, 0);
    check_eq("arst_err_count", err_count, 0);
    check_eq("arst_wrap_count", wrap_count, 0);
    check_eq("arst_err_pulse", err_pulse, 0);
    #3 reset = 1'b1;

    // First sample after reset goes to SYNC; held samples freeze state.
    drive(4'd4, 1'b0);
    check_eq("post_rst_expected", expected, 5);
    check_eq("post_rst_locked", locked, 0);
    drive(4'd5, 1'b0);
    for (int v = 10; v <= 14; v++) idle(4'(v));
    check_eq("hold_expected", expected, 6);
    check_eq("hold_locked", locked, 0);
    drive(4'd6, 1'b0);
    check_eq("hold_run_early", locked, 0);
    drive(4'd7, 1'b0);
    check_eq("hold_run_lock", locked, 1);

    // Pulse drops on a disabled cycle.
    drive(4'd0, 1'b0);
    check_eq("restart2_pulse", restart_seen, 1);
    idle(4'd3);
    check_eq("restart2_drop", restart_seen, 0);
    check_eq("restart2_expected", expected, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
